// File: rtl/tone_detector_if.sv
// Interface for the tone detector: the square-wave input and the classification results.
// The detector connects through the slave modport; the driver or monitor uses master.
interface tone_detector_if #(
  parameter int unsigned CNT_W = 19
) ();
  logic             tone_in;
  logic             note_valid;
  logic [1:0]       note_code;
  logic [CNT_W-1:0] period_out;
  logic             locked;
  logic             timeout;

  modport master (
    output tone_in,
    input  note_valid,
    input  note_code,
    input  period_out,
    input  locked,
    input  timeout
  );

  modport slave (
    input  tone_in,
    output note_valid,
    output note_code,
    output period_out,
    output locked,
    output timeout
  );
endinterface

// File: rtl/tone_detector.sv
// Measures rise-to-rise period of a square wave in clock cycles and classifies it
// as C4/F4/C5, with a lock flag after LOCK_N consecutive identical notes.
module tone_detector #(
  parameter int unsigned CNT_W   = 19,
  parameter int unsigned P_C4    = 191571,
  parameter int unsigned P_F4    = 143266,
  parameter int unsigned P_C5    = 95602,
  parameter int unsigned TOL     = 2000,
  parameter int unsigned TIMEOUT = 250000,
  parameter int unsigned LOCK_N  = 4
) (
  input  logic           clk_50MHz,
  input  logic           reset,
  tone_detector_if.slave bus
);

  localparam int unsigned MW = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] C4_LO     = CNT_W'(P_C4 - TOL);
  localparam logic [CNT_W-1:0] C4_HI     = CNT_W'(P_C4 + TOL);
  localparam logic [CNT_W-1:0] F4_LO     = CNT_W'(P_F4 - TOL);
  localparam logic [CNT_W-1:0] F4_HI     = CNT_W'(P_F4 + TOL);
  localparam logic [CNT_W-1:0] C5_LO     = CNT_W'(P_C5 - TOL);
  localparam logic [CNT_W-1:0] C5_HI     = CNT_W'(P_C5 + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [MW-1:0]    LOCK_MAX  = MW'(LOCK_N);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [1:0]       note_code_q, note_code_d;
  logic [MW-1:0]    match_q, match_d;
  logic             note_valid_q, note_valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  logic             rise;
  logic             at_limit;
  logic [1:0]       code_new;
  logic [MW-1:0]    match_new;

  // First window that contains the period wins; the windows are disjoint at the defaults.
  function automatic logic [1:0] classify(input logic [CNT_W-1:0] p);
    logic [1:0] code;
    if ((p >= C4_LO) && (p <= C4_HI)) begin
      code = 2'd1;
    end else if ((p >= F4_LO) && (p <= F4_HI)) begin
      code = 2'd2;
    end else if ((p >= C5_LO) && (p <= C5_HI)) begin
      code = 2'd3;
    end else begin
      code = 2'd0;
    end
    return code;
  endfunction

  assign sync_d   = {sync_q[1:0], bus.tone_in};
  assign rise     = sync_q[1] & ~sync_q[2];
  assign at_limit = (cnt_q == TIMEOUT_C);
  assign code_new = classify(cnt_q);

  // Run length of identical nonzero notes, used to derive the lock flag.
  always_comb begin
    match_new = match_q;
    if (code_new == 2'd0) begin
      match_new = MW'(0);
    end else if (code_new == note_code_q) begin
      if (match_q == LOCK_MAX) begin
        match_new = match_q;
      end else begin
        match_new = match_q + MW'(1);
      end
    end else begin
      match_new = MW'(1);
    end
  end

  // All state, synchroniser and output registers.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sync_q       <= 3'b000;
      cnt_q        <= CNT_ZERO;
      period_q     <= CNT_ZERO;
      note_code_q  <= 2'd0;
      match_q      <= MW'(0);
      note_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      note_code_q  <= note_code_d;
      match_q      <= match_d;
      note_valid_q <= note_valid_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state logic: a timeout without a coinciding rise returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEAS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEAS: begin
        if (at_limit && !rise) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MEAS;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter and result updates; a rise on the timeout cycle counts as a timeout and restarts.
  always_comb begin
    cnt_d        = cnt_q;
    period_d     = period_q;
    note_code_d  = note_code_q;
    match_d      = match_q;
    locked_d     = locked_q;
    note_valid_d = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          cnt_d = CNT_ONE;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      ST_MEAS: begin
        if (at_limit) begin
          timeout_d   = 1'b1;
          note_code_d = 2'd0;
          locked_d    = 1'b0;
          match_d     = MW'(0);
          if (rise) begin
            cnt_d = CNT_ONE;
          end else begin
            cnt_d = CNT_ZERO;
          end
        end else if (rise) begin
          note_valid_d = 1'b1;
          period_d     = cnt_q;
          note_code_d  = code_new;
          match_d      = match_new;
          locked_d     = (match_new == LOCK_MAX);
          cnt_d        = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: cnt_d = CNT_ZERO;
    endcase
  end

  assign bus.note_valid = note_valid_q;
  assign bus.note_code  = note_code_q;
  assign bus.period_out = period_q;
  assign bus.locked     = locked_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_tone_detector.sv
// Scoreboard bench for tone_detector with note periods scaled down by 100 so the run stays short.
module tb_tone_detector;

  localparam int CNT_W   = 19;
  localparam int P_C4    = 1916;
  localparam int P_F4    = 1433;
  localparam int P_C5    = 956;
  localparam int TOL     = 20;
  localparam int TIMEOUT = 2500;
  localparam int LOCK_N  = 4;

  typedef struct {
    int period;
    int code;
    bit locked;
  } exp_t;

  logic clk_50MHz = 1'b0;
  logic reset     = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  exp_t sb_q[$];
  int   valid_cnt        = 0;
  int   timeout_cnt      = 0;
  int   last_valid_cyc   = 0;
  int   last_timeout_cyc = 0;

  bit have_prev     = 1'b0;
  int last_rise_cyc = 0;
  int m_code        = 0;
  int m_match       = 0;

  tone_detector_if #(.CNT_W(CNT_W)) bus ();

  tone_detector #(
    .CNT_W(CNT_W), .P_C4(P_C4), .P_F4(P_F4), .P_C5(P_C5),
    .TOL(TOL), .TIMEOUT(TIMEOUT), .LOCK_N(LOCK_N)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .reset(reset),
    .bus(bus)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  always @(posedge clk_50MHz) cyc++;

  function automatic int model_classify(input int p);
    if (p >= P_C4 - TOL && p <= P_C4 + TOL) return 1;
    if (p >= P_F4 - TOL && p <= P_F4 + TOL) return 2;
    if (p >= P_C5 - TOL && p <= P_C5 + TOL) return 3;
    return 0;
  endfunction

  // Monitor: pops the scoreboard on every note_valid and checks timeout side effects.
  always @(negedge clk_50MHz) begin : mon
    exp_t e;
    if (bus.note_valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: note_valid=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = sb_q.pop_front();
        if (bus.period_out !== CNT_W'(e.period) || bus.note_code !== 2'(e.code) ||
            bus.locked !== e.locked) begin
          errors++;
          $display("FAIL sb_result: period=%0d code=%0d locked=%0d, required period=%0d code=%0d locked=%0d",
                   bus.period_out, bus.note_code, bus.locked, e.period, e.code, e.locked);
        end
      end
    end
    if (bus.timeout === 1'b1) begin
      timeout_cnt++;
      last_timeout_cyc = cyc;
      checks++;
      if (bus.note_code !== 2'd0 || bus.locked !== 1'b0) begin
        errors++;
        $display("FAIL timeout_clear: code=%0d locked=%0d, required code=0 locked=0",
                 bus.note_code, bus.locked);
      end
    end
  end

  // Drive a rising edge and record what the detector should report for the period it ends.
  task automatic do_rise();
    int len;
    int code;
    exp_t e;
    bus.tone_in = 1'b1;
    if (have_prev) begin
      len = cyc - last_rise_cyc;
      if (len < TIMEOUT) begin
        code = model_classify(len);
        if (code != 0 && code == m_code) m_match = (m_match < LOCK_N) ? m_match + 1 : m_match;
        else if (code != 0) m_match = 1;
        else m_match = 0;
        m_code = code;
        e.period = len;
        e.code   = code;
        e.locked = (m_match == LOCK_N);
        sb_q.push_back(e);
      end else begin
        m_code  = 0;
        m_match = 0;
      end
    end
    have_prev     = 1'b1;
    last_rise_cyc = cyc;
  endtask

  task automatic one_period(input int len);
    do_rise();
    repeat (len / 2) @(negedge clk_50MHz);
    bus.tone_in = 1'b0;
    repeat (len - len / 2) @(negedge clk_50MHz);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (bus.note_valid !== 1'b0 || bus.note_code !== 2'd0 || bus.period_out !== '0 ||
        bus.locked !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s: valid=%0d code=%0d period=%0d locked=%0d timeout=%0d, required all 0",
               tag, bus.note_valid, bus.note_code, bus.period_out, bus.locked, bus.timeout);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.tone_in = 1'b0;
    repeat (5) @(negedge clk_50MHz);
    check_all_zero("reset_state");
    reset = 1'b0;
    repeat (3) @(negedge clk_50MHz);
  endtask

  task automatic test_c4();
    int v0;
    v0 = valid_cnt;
    repeat (6) one_period(P_C4);
    checks++;
    if (valid_cnt - v0 != 5) begin
      errors++;
      $display("FAIL c4_pulses: got %0d note_valid pulses, required 5", valid_cnt - v0);
    end
    checks++;
    if (bus.locked !== 1'b1 || bus.note_code !== 2'd1) begin
      errors++;
      $display("FAIL c4_lock: locked=%0d code=%0d, required locked=1 code=1", bus.locked, bus.note_code);
    end
  endtask

  task automatic test_f4_c5();
    repeat (5) one_period(P_F4);
    repeat (5) one_period(P_C5);
    checks++;
    if (bus.locked !== 1'b1 || bus.note_code !== 2'd3) begin
      errors++;
      $display("FAIL c5_relock: locked=%0d code=%0d, required locked=1 code=3", bus.locked, bus.note_code);
    end
  endtask

  task automatic test_timeout();
    int t0;
    int v0;
    t0 = timeout_cnt;
    v0 = valid_cnt;
    bus.tone_in = 1'b0;
    for (int i = 0; i < 2 * TIMEOUT && timeout_cnt == t0; i++) @(negedge clk_50MHz);
    @(negedge clk_50MHz);
    checks++;
    if (timeout_cnt != t0 + 1) begin
      errors++;
      $display("FAIL timeout_seen: got %0d pulses, required 1", timeout_cnt - t0);
    end else if (last_timeout_cyc - last_valid_cyc != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles, required %0d", last_timeout_cyc - last_valid_cyc, TIMEOUT);
    end
    checks++;
    if (valid_cnt != v0 || bus.locked !== 1'b0 || bus.note_code !== 2'd0) begin
      errors++;
      $display("FAIL timeout_state: valids=%0d locked=%0d code=%0d, required 0 0 0",
               valid_cnt - v0, bus.locked, bus.note_code);
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    repeat (5) one_period(P_C5);
    do_rise();
    repeat (P_C5 / 2) @(negedge clk_50MHz);
    bus.tone_in = 1'b0;
    repeat (200) @(negedge clk_50MHz);
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_lock: locked=%0d, required 1", bus.locked);
    end
    reset = 1'b1;
    @(negedge clk_50MHz);
    reset = 1'b0;
    check_all_zero("reset_mid");
    have_prev = 1'b0;
    m_code    = 0;
    m_match   = 0;
    repeat (P_C5 - P_C5 / 2 - 201) @(negedge clk_50MHz);
    v0 = valid_cnt;
    one_period(P_C5);
    checks++;
    if (valid_cnt != v0) begin
      errors++;
      $display("FAIL reset_first_rise: got %0d pulses, required 0", valid_cnt - v0);
    end
    one_period(P_C5);
    checks++;
    if (valid_cnt != v0 + 1) begin
      errors++;
      $display("FAIL reset_second_rise: got %0d pulses, required 1", valid_cnt - v0);
    end
  endtask

  task automatic test_boundary();
    one_period(P_C4 + TOL + 1);
    one_period(P_C4 + TOL);
    checks++;
    if (bus.note_code !== 2'd0 || bus.locked !== 1'b0 || bus.period_out !== CNT_W'(P_C4 + TOL + 1)) begin
      errors++;
      $display("FAIL bound_outside: code=%0d locked=%0d period=%0d, required 0 0 %0d",
               bus.note_code, bus.locked, bus.period_out, P_C4 + TOL + 1);
    end
    one_period(P_C5);
    checks++;
    if (bus.note_code !== 2'd1 || bus.period_out !== CNT_W'(P_C4 + TOL)) begin
      errors++;
      $display("FAIL bound_inside: code=%0d period=%0d, required 1 %0d",
               bus.note_code, bus.period_out, P_C4 + TOL);
    end
  endtask

  task automatic test_forced_rise();
    int t0;
    int v1;
    t0 = timeout_cnt;
    one_period(TIMEOUT);
    v1 = valid_cnt;
    one_period(P_C5);
    checks++;
    if (timeout_cnt != t0 + 1 || valid_cnt != v1) begin
      errors++;
      $display("FAIL forced_timeout: timeouts=%0d valids=%0d, required 1 0", timeout_cnt - t0, valid_cnt - v1);
    end
    checks++;
    if (last_timeout_cyc - last_valid_cyc != TIMEOUT) begin
      errors++;
      $display("FAIL forced_delay: got %0d cycles, required %0d", last_timeout_cyc - last_valid_cyc, TIMEOUT);
    end
    one_period(P_C5);
    do_rise();
    repeat (10) @(negedge clk_50MHz);
    bus.tone_in = 1'b0;
    checks++;
    if (valid_cnt != v1 + 2 || bus.period_out !== CNT_W'(P_C5) || bus.note_code !== 2'd3) begin
      errors++;
      $display("FAIL forced_after: valids=%0d period=%0d code=%0d, required 2 %0d 3",
               valid_cnt - v1, bus.period_out, bus.note_code, P_C5);
    end
  endtask

  initial begin
    bus.tone_in = 1'b0;
    test_reset();
    test_c4();
    test_f4_c5();
    test_timeout();
    test_reset_mid();
    test_boundary();
    test_forced_rise();
    repeat (20) @(negedge clk_50MHz);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected results never reported, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
